sramlike_axi_bridge: RTL and testbench

- Sits directly downstream of the core's SRAM-like instruction and data ports.
- Arbitrates the two ports and converts each accepted request into a single-beat AXI4 transaction on one 32-bit master port.
- Gives SRAM-like builds of the core access to the AXI memory system.
- One transaction is outstanding at a time; the data port wins ties.

---
 rtl/sramlike_axi_bridge_pkg.sv | 8 +
 rtl/sramlike_axi_bridge_if.sv | 64 ++++++
 rtl/sramlike_arb.sv | 17 +
 rtl/sramlike_axi_bridge.sv | 134 +++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sramlike_axi_bridge_pkg.sv
// sramlike_axi_bridge_pkg: shared FSM encoding, AXI constants and port-owner type
package sramlike_axi_bridge_pkg;
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
   typedef enum logic {OWN_INST, OWN_DATA} owner_t;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [7:0] LEN_1      = 8'd0;
endpackage

// File: rtl/sramlike_axi_bridge_if.sv
// axi_master_if: AXI4 bundle with master and slave views
interface axi_master_if #(parameter int DW = 32, parameter int IW = 1);
   logic [IW-1:0]   awid;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic [3:0]      awqos;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;
   logic [IW-1:0]   bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [IW-1:0]   arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic [3:0]      arqos;
   logic            arvalid;
   logic            arready;
   logic [IW-1:0]   rid;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/sramlike_arb.sv
// sramlike_arb: fixed-priority grant between inst and data ports, data wins ties
module sramlike_arb
   import sramlike_axi_bridge_pkg::*;
(
   input  logic       en,
   input  logic [3:0] inst_cen,
   input  logic [3:0] data_cen,
   output logic       gnt,
   output owner_t     gnt_owner,
   output logic       inst_ack,
   output logic       data_ack
);
   assign data_ack  = en && |data_cen;
   assign inst_ack  = en && !(|data_cen) && |inst_cen;
   assign gnt       = data_ack || inst_ack;
   assign gnt_owner = data_ack ? OWN_DATA : OWN_INST;
endmodule

// File: rtl/sramlike_axi_bridge.sv
// sramlike_axi_bridge: arbitrates SRAM-like inst/data ports onto one AXI4 master,
// one single-beat transaction outstanding at a time
module sramlike_axi_bridge
   import sramlike_axi_bridge_pkg::*;
#(
   parameter logic INST_ID    = 1'b0,
   parameter logic DATA_ID    = 1'b1,
   parameter bit   ALIGN_ADDR = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  inst_sram_cen,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        inst_sram_wr,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_ack,
   output logic        inst_sram_rrdy,
   input  logic [3:0]  data_sram_cen,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic        data_sram_wr,
   input  logic [31:0] data_sram_addr,
   output logic        data_sram_ack,
   output logic        data_sram_rrdy,
   axi_master_if.master m_axi
);
   state_t      state;
   owner_t      owner;
   owner_t      gnt_owner;
   logic        gnt;
   logic        sel_data;
   logic [31:0] raw_addr;
   logic [31:0] sel_addr;
   logic        unused_ok;
   sramlike_arb u_arb (
      .en        (state == IDLE && reset),
      .inst_cen  (inst_sram_cen),
      .data_cen  (data_sram_cen),
      .gnt       (gnt),
      .gnt_owner (gnt_owner),
      .inst_ack  (inst_sram_ack),
      .data_ack  (data_sram_ack)
   );
   assign sel_data  = gnt_owner == OWN_DATA;
   assign raw_addr  = sel_data ? data_sram_addr : inst_sram_addr;
   assign sel_addr  = ALIGN_ADDR ? {raw_addr[31:2], 2'b00} : raw_addr;
   assign unused_ok = ^{m_axi.bid, m_axi.bresp, m_axi.rid, m_axi.rresp, m_axi.rlast};
   assign m_axi.arlen   = LEN_1;
   assign m_axi.arsize  = SIZE_4B;
   assign m_axi.arburst = BURST_INCR;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = 4'd0;
   assign m_axi.arprot  = 3'd0;
   assign m_axi.arqos   = 4'd0;
   assign m_axi.awlen   = LEN_1;
   assign m_axi.awsize  = SIZE_4B;
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = 4'd0;
   assign m_axi.awprot  = 3'd0;
   assign m_axi.awqos   = 4'd0;
   assign m_axi.wlast   = 1'b1;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         owner           <= OWN_INST;
         m_axi.arvalid   <= 1'b0;
         m_axi.awvalid   <= 1'b0;
         m_axi.wvalid    <= 1'b0;
         m_axi.rready    <= 1'b0;
         m_axi.bready    <= 1'b0;
         m_axi.arid      <= '0;
         m_axi.awid      <= '0;
         m_axi.araddr    <= '0;
         m_axi.awaddr    <= '0;
         m_axi.wdata     <= '0;
         m_axi.wstrb     <= '0;
         inst_sram_rdata <= '0;
         data_sram_rdata <= '0;
         inst_sram_rrdy  <= 1'b0;
         data_sram_rrdy  <= 1'b0;
      end else begin
         inst_sram_rrdy <= 1'b0;
         data_sram_rrdy <= 1'b0;
         case (state)
            IDLE: if (gnt) begin
               owner        <= gnt_owner;
               m_axi.arid   <= sel_data ? DATA_ID : INST_ID;
               m_axi.awid   <= sel_data ? DATA_ID : INST_ID;
               m_axi.araddr <= sel_addr;
               m_axi.awaddr <= sel_addr;
               m_axi.wdata  <= sel_data ? data_sram_wdata : inst_sram_wdata;
               m_axi.wstrb  <= sel_data ? data_sram_cen : inst_sram_cen;
               if (sel_data ? data_sram_wr : inst_sram_wr) begin
                  m_axi.awvalid <= 1'b1;
                  m_axi.wvalid  <= 1'b1;
                  state         <= WR_REQ;
               end else begin
                  m_axi.arvalid <= 1'b1;
                  state         <= RD_ADDR;
               end
            end
            RD_ADDR: if (m_axi.arready) begin
               m_axi.arvalid <= 1'b0;
               m_axi.rready  <= 1'b1;
               state         <= RD_DATA;
            end
            RD_DATA: if (m_axi.rvalid) begin
               m_axi.rready <= 1'b0;
               if (owner == OWN_DATA) data_sram_rdata <= m_axi.rdata;
               else inst_sram_rdata <= m_axi.rdata;
               {data_sram_rrdy, inst_sram_rrdy} <= owner == OWN_DATA ? 2'b10 : 2'b01;
               state <= DONE;
            end
            // AW and W complete independently; a low valid means that handshake is done
            WR_REQ: begin
               if (m_axi.awready) m_axi.awvalid <= 1'b0;
               if (m_axi.wready) m_axi.wvalid <= 1'b0;
               if ((m_axi.awready || !m_axi.awvalid) && (m_axi.wready || !m_axi.wvalid)) begin
                  m_axi.bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: if (m_axi.bvalid) begin
               m_axi.bready <= 1'b0;
               {data_sram_rrdy, inst_sram_rrdy} <= owner == OWN_DATA ? 2'b10 : 2'b01;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// tb_sramlike_axi_bridge: directed checks of arbitration, AXI sequencing and async reset
module tb_sramlike_axi_bridge;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  inst_sram_cen, data_sram_cen;
   logic [31:0] inst_sram_wdata, data_sram_wdata, inst_sram_addr, data_sram_addr;
   logic [31:0] inst_sram_rdata, data_sram_rdata;
   logic        inst_sram_wr, data_sram_wr;
   logic        inst_sram_ack, data_sram_ack, inst_sram_rrdy, data_sram_rrdy;
   int          n_chk = 0;
   int          n_fail = 0;
   axi_master_if #(.DW(32), .IW(1)) axi ();
   sramlike_axi_bridge dut (
      .clk             (clk),
      .reset           (reset),
      .inst_sram_cen   (inst_sram_cen),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .inst_sram_wr    (inst_sram_wr),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_ack   (inst_sram_ack),
      .inst_sram_rrdy  (inst_sram_rrdy),
      .data_sram_cen   (data_sram_cen),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .data_sram_wr    (data_sram_wr),
      .data_sram_addr  (data_sram_addr),
      .data_sram_ack   (data_sram_ack),
      .data_sram_rrdy  (data_sram_rrdy),
      .m_axi           (axi)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      reset = 1'b0;
      inst_sram_cen = 4'h0; inst_sram_wdata = '0; inst_sram_addr = '0; inst_sram_wr = 1'b0;
      data_sram_cen = 4'h0; data_sram_wdata = '0; data_sram_addr = '0; data_sram_wr = 1'b0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rresp = 2'b00; axi.rlast = 1'b1;
      axi.rdata = '0;
      repeat (2) tick();
      chk("rst_arvalid", 32'(axi.arvalid), 0);
      chk("rst_awvalid", 32'(axi.awvalid), 0);
      chk("rst_wvalid", 32'(axi.wvalid), 0);
      chk("rst_rready", 32'(axi.rready), 0);
      chk("rst_bready", 32'(axi.bready), 0);
      chk("rst_inst_rrdy", 32'(inst_sram_rrdy), 0);
      chk("rst_inst_rdata", inst_sram_rdata, 0);
      reset = 1'b1;
      // inst read, zero-wait slave
      inst_sram_addr = 32'hBFC00000; inst_sram_cen = 4'hF; inst_sram_wr = 1'b0;
      #1;
      chk("t1_inst_ack", 32'(inst_sram_ack), 1);
      chk("t1_data_ack", 32'(data_sram_ack), 0);
      tick();
      inst_sram_cen = 4'h0;
      chk("t1_arvalid", 32'(axi.arvalid), 1);
      chk("t1_araddr", axi.araddr, 32'hBFC00000);
      chk("t1_arid", 32'(axi.arid), 0);
      chk("t1_arlen", 32'(axi.arlen), 0);
      chk("t1_arsize", 32'(axi.arsize), 2);
      chk("t1_arburst", 32'(axi.arburst), 1);
      chk("t1_ack_gone", 32'(inst_sram_ack), 0);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      chk("t1_arvalid_drop", 32'(axi.arvalid), 0);
      chk("t1_rready", 32'(axi.rready), 1);
      axi.rvalid = 1'b1; axi.rdata = 32'h3C1D8000;
      tick();
      axi.rvalid = 1'b0;
      chk("t1_inst_rrdy", 32'(inst_sram_rrdy), 1);
      chk("t1_inst_rdata", inst_sram_rdata, 32'h3C1D8000);
      chk("t1_data_rrdy", 32'(data_sram_rrdy), 0);
      chk("t1_rready_drop", 32'(axi.rready), 0);
      tick();
      chk("t1_rrdy_pulse", 32'(inst_sram_rrdy), 0);
      // data write with unaligned address
      data_sram_addr = 32'h80001002; data_sram_wdata = 32'hAABBCCDD; data_sram_cen = 4'b1100;
      data_sram_wr = 1'b1;
      #1;
      chk("t2_data_ack", 32'(data_sram_ack), 1);
      tick();
      data_sram_cen = 4'h0;
      chk("t2_awvalid", 32'(axi.awvalid), 1);
      chk("t2_wvalid", 32'(axi.wvalid), 1);
      chk("t2_awaddr", axi.awaddr, 32'h80001000);
      chk("t2_wstrb", 32'(axi.wstrb), 32'hC);
      chk("t2_awid", 32'(axi.awid), 1);
      chk("t2_wdata", axi.wdata, 32'hAABBCCDD);
      chk("t2_wlast", 32'(axi.wlast), 1);
      chk("t2_bready_early", 32'(axi.bready), 0);
      axi.awready = 1'b1; axi.wready = 1'b1;
      tick();
      axi.awready = 1'b0; axi.wready = 1'b0;
      chk("t2_awvalid_drop", 32'(axi.awvalid), 0);
      chk("t2_wvalid_drop", 32'(axi.wvalid), 0);
      chk("t2_bready", 32'(axi.bready), 1);
      chk("t2_rrdy_early", 32'(data_sram_rrdy), 0);
      axi.bvalid = 1'b1;
      tick();
      axi.bvalid = 1'b0;
      chk("t2_data_rrdy", 32'(data_sram_rrdy), 1);
      chk("t2_inst_rrdy", 32'(inst_sram_rrdy), 0);
      chk("t2_bready_drop", 32'(axi.bready), 0);
      tick();
      chk("t2_rrdy_pulse", 32'(data_sram_rrdy), 0);
      // simultaneous inst and data reads
      inst_sram_addr = 32'h00001000; inst_sram_cen = 4'hF; inst_sram_wr = 1'b0;
      data_sram_addr = 32'h00002004; data_sram_cen = 4'hF; data_sram_wr = 1'b0;
      #1;
      chk("t3_data_ack", 32'(data_sram_ack), 1);
      chk("t3_inst_ack", 32'(inst_sram_ack), 0);
      tick();
      data_sram_cen = 4'h0;
      chk("t3_arid_data", 32'(axi.arid), 1);
      chk("t3_araddr_data", axi.araddr, 32'h00002004);
      chk("t3_inst_wait", 32'(inst_sram_ack), 0);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      axi.rvalid = 1'b1; axi.rdata = 32'h11111111;
      tick();
      axi.rvalid = 1'b0;
      chk("t3_data_rrdy", 32'(data_sram_rrdy), 1);
      chk("t3_inst_rrdy_no", 32'(inst_sram_rrdy), 0);
      chk("t3_done_no_ack", 32'(inst_sram_ack), 0);
      chk("t3_data_rdata", data_sram_rdata, 32'h11111111);
      tick();
      chk("t3_inst_ack_late", 32'(inst_sram_ack), 1);
      tick();
      inst_sram_cen = 4'h0;
      chk("t3_arid_inst", 32'(axi.arid), 0);
      chk("t3_araddr_inst", axi.araddr, 32'h00001000);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      axi.rvalid = 1'b1; axi.rdata = 32'h22222222;
      tick();
      axi.rvalid = 1'b0;
      chk("t3_inst_rrdy", 32'(inst_sram_rrdy), 1);
      chk("t3_data_rrdy_no", 32'(data_sram_rrdy), 0);
      chk("t3_inst_rdata", inst_sram_rdata, 32'h22222222);
      chk("t3_data_rdata_kept", data_sram_rdata, 32'h11111111);
      tick();
      // write with awready delayed, wready immediate
      data_sram_addr = 32'h00000010; data_sram_wdata = 32'h12345678; data_sram_cen = 4'hF;
      data_sram_wr = 1'b1;
      #1;
      chk("t4_data_ack", 32'(data_sram_ack), 1);
      tick();
      data_sram_cen = 4'h0;
      chk("t4_awvalid_c1", 32'(axi.awvalid), 1);
      chk("t4_wvalid_c1", 32'(axi.wvalid), 1);
      axi.wready = 1'b1;
      tick();
      axi.wready = 1'b0;
      chk("t4_wvalid_c2", 32'(axi.wvalid), 0);
      chk("t4_awvalid_c2", 32'(axi.awvalid), 1);
      chk("t4_bready_c2", 32'(axi.bready), 0);
      tick();
      chk("t4_awvalid_c3", 32'(axi.awvalid), 1);
      chk("t4_bready_c3", 32'(axi.bready), 0);
      axi.awready = 1'b1;
      tick();
      axi.awready = 1'b0;
      chk("t4_awvalid_c4", 32'(axi.awvalid), 0);
      chk("t4_bready_c4", 32'(axi.bready), 1);
      axi.bvalid = 1'b1;
      tick();
      axi.bvalid = 1'b0;
      chk("t4_data_rrdy", 32'(data_sram_rrdy), 1);
      tick();
      chk("t4_rrdy_single", 32'(data_sram_rrdy), 0);
      chk("t4_bready_drop", 32'(axi.bready), 0);
      // async reset while in RD_DATA with rvalid pending
      inst_sram_addr = 32'h00000100; inst_sram_cen = 4'hF; inst_sram_wr = 1'b0;
      #1;
      chk("t5_inst_ack", 32'(inst_sram_ack), 1);
      tick();
      chk("t5_arvalid", 32'(axi.arvalid), 1);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      chk("t5_rready", 32'(axi.rready), 1);
      axi.rvalid = 1'b1; axi.rdata = 32'hDEADBEEF;
      #1 reset = 1'b0;
      #1;
      chk("t5_rst_rready", 32'(axi.rready), 0);
      chk("t5_rst_arvalid", 32'(axi.arvalid), 0);
      chk("t5_rst_awvalid", 32'(axi.awvalid), 0);
      chk("t5_rst_bready", 32'(axi.bready), 0);
      chk("t5_rst_inst_ack", 32'(inst_sram_ack), 0);
      chk("t5_rst_inst_rdata", inst_sram_rdata, 0);
      chk("t5_rst_data_rdata", data_sram_rdata, 0);
      tick();
      axi.rvalid = 1'b0;
      chk("t5_no_rrdy", 32'(inst_sram_rrdy), 0);
      inst_sram_addr = 32'h00000200;
      reset = 1'b1;
      #1;
      chk("t5_post_ack", 32'(inst_sram_ack), 1);
      tick();
      inst_sram_cen = 4'h0;
      chk("t5_post_arvalid", 32'(axi.arvalid), 1);
      chk("t5_post_araddr", axi.araddr, 32'h00000200);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      axi.rvalid = 1'b1; axi.rdata = 32'hCAFEF00D;
      tick();
      axi.rvalid = 1'b0;
      chk("t5_post_rrdy", 32'(inst_sram_rrdy), 1);
      chk("t5_post_rdata", inst_sram_rdata, 32'hCAFEF00D);
      tick();
      // back-to-back data reads with stalled rvalid
      data_sram_addr = 32'h00003000; data_sram_cen = 4'hF; data_sram_wr = 1'b0;
      #1;
      chk("t6_ack1", 32'(data_sram_ack), 1);
      tick();
      chk("t6_arvalid1", 32'(axi.arvalid), 1);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t6_stall1_ack", 32'(data_sram_ack), 0);
         chk("t6_stall1_rrdy", 32'(data_sram_rrdy), 0);
         chk("t6_stall1_rdata", data_sram_rdata, 0);
         tick();
      end
      axi.rvalid = 1'b1; axi.rdata = 32'h55AA55AA;
      tick();
      axi.rvalid = 1'b0;
      chk("t6_rrdy1", 32'(data_sram_rrdy), 1);
      chk("t6_rdata1", data_sram_rdata, 32'h55AA55AA);
      chk("t6_done_no_ack", 32'(data_sram_ack), 0);
      tick();
      data_sram_addr = 32'h00003004;
      chk("t6_ack2", 32'(data_sram_ack), 1);
      chk("t6_rrdy1_pulse", 32'(data_sram_rrdy), 0);
      tick();
      chk("t6_araddr2", axi.araddr, 32'h00003004);
      chk("t6_no_ack_busy", 32'(data_sram_ack), 0);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t6_stall2_ack", 32'(data_sram_ack), 0);
         chk("t6_stall2_rdata", data_sram_rdata, 32'h55AA55AA);
         tick();
      end
      axi.rvalid = 1'b1; axi.rdata = 32'h66778899;
      tick();
      axi.rvalid = 1'b0; data_sram_cen = 4'h0;
      chk("t6_rrdy2", 32'(data_sram_rrdy), 1);
      chk("t6_rdata2", data_sram_rdata, 32'h66778899);
      tick();
      chk("t6_rrdy2_pulse", 32'(data_sram_rrdy), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
